// File: rtl/divisor_frequencia_prog.sv
// Programmable clock divider: q is low floor(D/2) and high D-floor(D/2) cycles.
// New divisors are staged and applied only at a period boundary (or at once when idle).
module divisor_frequencia_prog #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 27
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_ld,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic             q,
  output logic             tick,
  output logic [WIDTH-1:0] div_cur
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  logic [WIDTH-1:0] contador_q, contador_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             q_q, q_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             wrap, apply, ld_ok;

  // ">=" also catches a count left beyond a freshly shrunk divisor
  assign wrap  = en && (contador_q >= (div_act_q - ONE));
  assign apply = pend_q && (wrap || !en);
  assign ld_ok = div_ld && (div_in >= TWO);

  always_comb begin
    contador_d = contador_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    ack_d      = ld_ok;
    err_d      = div_ld && !ld_ok;

    if (apply) begin
      contador_d = '0;
      div_act_d  = div_pend_q;
      pend_d     = 1'b0;
    end else if (en) begin
      contador_d = wrap ? '0 : contador_q + ONE;
    end

    // a load on the apply edge becomes the next pending value
    if (ld_ok) begin
      div_pend_d = div_in;
      pend_d     = 1'b1;
    end

    // q is registered from the look-ahead count/divisor
    q_d = (contador_d >= (div_act_d >> 1));
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      contador_q <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      q_q        <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      contador_q <= contador_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      q_q        <= q_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign tick    = wrap;
  assign q       = q_q;
  assign busy    = pend_q;
  assign div_ack = ack_q;
  assign div_err = err_q;
  assign div_cur = div_act_q;

endmodule

// File: tb/tb_divisor_frequencia_prog.sv
// Directed bench for divisor_frequencia_prog: a period-level model checked every
// cycle, plus literal duty/tick/handshake expectations per scenario.
module tb_divisor_frequencia_prog;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_ld = 1'b0;
  logic        div_ack, div_err, busy, q, tick;
  logic [15:0] div_cur;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: position inside the current period, divisor, staged load
  int m_cnt = 0, m_D = 27, m_pv = 0;
  bit m_pend = 0, m_ack = 0, m_err = 0;

  divisor_frequencia_prog #(.WIDTH(16), .DIV_DEFAULT(27)) dut (
    .clk(clk), .clr(clr), .en(en), .div_in(div_in), .div_ld(div_ld),
    .div_ack(div_ack), .div_err(div_err), .busy(busy), .q(q),
    .tick(tick), .div_cur(div_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_cnt  <= 0;
      m_D    <= 27;
      m_pv   <= 0;
      m_pend <= 0;
      m_ack  <= 0;
      m_err  <= 0;
    end else begin : mdl
      bit last, swap, ok;
      last = en && (m_cnt == m_D - 1 || m_cnt > m_D - 1);
      swap = m_pend && (last || !en);
      ok   = div_ld && int'(div_in) >= 2;
      m_ack <= ok;
      m_err <= div_ld && !ok;
      if (swap) begin
        m_cnt <= 0;
        m_D   <= m_pv;
      end else if (en) begin
        m_cnt <= last ? 0 : m_cnt + 1;
      end
      if (ok) begin
        m_pv   <= int'(div_in);
        m_pend <= 1;
      end else if (swap) begin
        m_pend <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (clr) begin
      chk("q", int'(q), int'(m_cnt >= m_D / 2));
      chk("tick", int'(tick), int'(en && m_cnt >= m_D - 1));
      chk("busy", int'(busy), int'(m_pend));
      chk("div_cur", int'(div_cur), m_D);
      chk("div_ack", int'(div_ack), int'(m_ack));
      chk("div_err", int'(div_err), int'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic win(input int n, output int hi, output int tk);
    hi = 0;
    tk = 0;
    repeat (n) begin
      hi += int'(q);
      tk += int'(tick);
      step();
    end
  endtask

  task automatic load(input int v);
    div_ld = 1'b1;
    div_in = 16'(v);
  endtask

  initial begin
    int hi, tk, b, k;
    #1 clr = 1'b0;
    #2;
    chk("rst_q", int'(q), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_div_cur", int'(div_cur), 27);
    chk("rst_ack", int'(div_ack), 0);
    chk("rst_err", int'(div_err), 0);
    step();
    clr = 1'b1;
    en  = 1'b1;

    // default D=27: two periods
    win(54, hi, tk);
    chk("d27_high", hi, 28);
    chk("d27_ticks", tk, 2);
    chk("d27_cur", int'(div_cur), 27);

    // illegal divisors rejected
    load(1); step();
    chk("err1", int'(div_err), 1); chk("err1_ack", int'(div_ack), 0);
    chk("err1_busy", int'(busy), 0);
    div_in = 16'd0; step();
    chk("err0", int'(div_err), 1); chk("err0_ack", int'(div_ack), 0);
    chk("err0_cur", int'(div_cur), 27);
    div_ld = 1'b0;

    // load 10 at count 5, applied at the wrap after count 26
    repeat (3) step();
    load(10); step(); div_ld = 1'b0;
    chk("ld10_ack", int'(div_ack), 1);
    chk("ld10_busy", int'(busy), 1);
    b = 0;
    repeat (21) begin b += int'(busy); step(); end
    chk("ld10_busy_len", b, 21);
    chk("ld10_applied", int'(div_cur), 10);
    chk("ld10_busy_clr", int'(busy), 0);
    win(20, hi, tk);
    chk("d10_high", hi, 10);
    chk("d10_ticks", tk, 2);

    // pause mid-period
    repeat (6) step();
    en = 1'b0;
    win(7, hi, tk);
    chk("pause_q_held", hi, 7);
    chk("pause_ticks", tk, 0);
    chk("pause_cur", int'(div_cur), 10);
    en = 1'b1;
    k = 0;
    while (!tick && k < 50) begin step(); k++; end
    chk("period_after_pause", 6 + k + 1, 10);
    step();

    // load while disabled applies on the next edge with count cleared
    repeat (3) step();
    en = 1'b0;
    load(4); step(); div_ld = 1'b0;
    chk("idle_ld_ack", int'(div_ack), 1);
    chk("idle_ld_busy", int'(busy), 1);
    step();
    chk("idle_ld_cur", int'(div_cur), 4);
    chk("idle_ld_busy0", int'(busy), 0);
    en = 1'b1;
    win(8, hi, tk);
    chk("d4_high", hi, 4);
    chk("d4_ticks", tk, 2);

    // 4 then 6 before the wrap: last one wins
    load(4); step(); chk("ld4_ack", int'(div_ack), 1);
    div_ld = 1'b0; step();
    load(6); step(); chk("ld6_ack", int'(div_ack), 1);
    chk("ld6_cur_old", int'(div_cur), 4);
    div_ld = 1'b0; step();
    chk("ld6_applied", int'(div_cur), 6);
    chk("ld6_busy0", int'(busy), 0);

    // load 8 on a wrap edge with nothing pending: applies one period later
    repeat (5) step();
    load(8); step(); div_ld = 1'b0;
    chk("ld8_ack", int'(div_ack), 1);
    chk("ld8_busy", int'(busy), 1);
    chk("ld8_cur_old", int'(div_cur), 6);
    win(6, hi, tk);
    chk("d6_high", hi, 3);
    chk("d6_ticks", tk, 1);
    chk("ld8_applied", int'(div_cur), 8);

    // load on a wrap edge while pending: old applies, new stays pending
    load(3); step(); div_ld = 1'b0;
    repeat (6) step();
    load(5); step(); div_ld = 1'b0;
    chk("wrap_pend_cur", int'(div_cur), 3);
    chk("wrap_pend_busy", int'(busy), 1);
    repeat (3) step();
    chk("wrap_pend_next", int'(div_cur), 5);

    // D=2
    en = 1'b0;
    load(2); step(); div_ld = 1'b0; step();
    en = 1'b1;
    win(8, hi, tk);
    chk("d2_high", hi, 4);
    chk("d2_ticks", tk, 4);
    chk("d2_cur", int'(div_cur), 2);

    // async reset with a load pending
    load(9); step(); div_ld = 1'b0;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_q", int'(q), 1);
    #2 clr = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ack", int'(div_ack), 0);
    chk("arst_cur", int'(div_cur), 27);
    step(); step();
    clr = 1'b1;
    win(27, hi, tk);
    chk("post_rst_high", hi, 14);
    chk("post_rst_ticks", tk, 1);
    chk("post_rst_cur", int'(div_cur), 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/divisor_frequencia_prog.md
DIVISOR_FREQUENCIA_PROG -- requirements
Module: divisor_frequencia_prog

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: bit width of the counter and divisor, legal range 2..32.
REQ-002 The block SHALL have parameter DIV_DEFAULT, default 27: divisor after reset (27 MHz -> 1 MHz), legal range 2..2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port div_in, input, WIDTH bits: the new divisor value.
REQ-007 The block SHALL have port div_ld, input, 1 bit: a one-cycle load strobe for div_in.
REQ-008 The block SHALL have port div_ack, output, 1 bit: a one-cycle pulse meaning the load was accepted.
REQ-009 The block SHALL have port div_err, output, 1 bit: a one-cycle pulse meaning the load was rejected.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an accepted divisor is pending.
REQ-011 The block SHALL have port q, output, 1 bit: the divided clock, registered.
REQ-012 The block SHALL have port tick, output, 1 bit: a one-cycle pulse on the last count of each period.
REQ-013 The block SHALL have port div_cur, output, WIDTH bits: the divisor currently in use (div_act).

Function
REQ-014 Internal state SHALL be: contador (WIDTH), div_act (WIDTH), div_pend (WIDTH) and a pend flag; busy SHALL equal pend.
REQ-015 When en=1, contador SHALL increment by 1 each cycle.
REQ-016 When en=1 and contador >= div_act-1, contador SHALL wrap to 0 on the next edge; ">=" also covers an out-of-range count after a divisor change.
REQ-017 In every cycle, q SHALL equal (contador >= div_act>>1), with integer floor, so q is low for floor(D/2) cycles and high for D-floor(D/2) cycles.
REQ-018 q SHALL come from a flop loaded with the look-ahead value, not from combinational decode.
REQ-019 tick SHALL be 1 exactly when en=1 and contador >= div_act-1, and 0 otherwise.
REQ-020 When en=0, contador and q SHALL hold and tick SHALL be 0.
REQ-021 div_ld=1 with div_in < 2 SHALL produce div_err=1 in the next cycle and leave all other state unchanged.
REQ-022 div_ld=1 with div_in >= 2 SHALL, on that edge, set div_pend=div_in and pend=1, and SHALL produce div_ack=1 in the next cycle.
REQ-023 A new div_ld while pend=1 SHALL overwrite div_pend (last value wins) and SHALL be acknowledged again.
REQ-024 The pending divisor SHALL be applied at the wrap edge (REQ-016): div_act=div_pend, pend=0, contador=0, and q SHALL take (0 >= new_D>>1), i.e. 0.
REQ-025 When en=0 and pend=1, the pending divisor SHALL be applied on the next edge in the same way, with contador forced to 0.
REQ-026 When div_ld coincides with a wrap edge and pend=1, the old div_pend SHALL be applied and the new value SHALL become pending (pend stays 1).
REQ-027 When div_ld coincides with a wrap edge and pend=0, the new value SHALL become pending and SHALL apply at the following wrap.
REQ-028 With D=2, q SHALL toggle every enabled cycle and tick SHALL assert every second enabled cycle.
REQ-029 div_cur SHALL change only at an apply edge, so no partial period is ever emitted.

Reset
REQ-030 While clr=0, the block SHALL asynchronously force contador=0, div_act=DIV_DEFAULT, div_pend=0, pend=0, q=0, tick=0, div_ack=0 and div_err=0.
REQ-031 A reset during a pending load SHALL discard the pending divisor.
REQ-032 After clr rises, the first enabled edge SHALL increment contador from 0.
REQ-033 Outputs SHALL be stable (no X) from reset assertion onward.

Verification
REQ-034 Reset, en=1, default D=27 -> q low 13 cycles and high 14 cycles, repeating; tick once every 27 cycles; div_cur=27.
REQ-035 Load div_in=10 at contador=5 -> div_ack the next cycle, busy=1 until the wrap at count 26; after that q shows 5 low / 5 high and tick every 10 cycles.
REQ-036 Load div_in=1, then div_in=0 -> div_err pulse for each, no div_ack; busy and div_cur=27 unchanged.
REQ-037 en=0 for 7 cycles mid-period -> contador, q and div_cur held, tick=0; after en=1 the period resumes and totals 27 enabled cycles; a load during en=0 applies next edge with contador=0.
REQ-038 Load 4 and then 6 before the wrap -> two div_ack pulses; 6 is applied at the wrap; a load of 8 exactly on a wrap edge with pend=0 applies one period later.
REQ-039 Pull clr low mid-period with busy=1 -> all outputs immediately 0 and div_cur=27 without waiting for clk; the pending divisor is never applied.
